// File: rtl/ysyx_24080014_lsu.sv
// ysyx_24080014_lsu -- single-outstanding load/store unit.
//
// Accepts one load or store request at a time. The request is checked for
// errors and alignment, then turned into an aligned memory bus access with
// byte strobes. Load data is shifted down, masked and extended before it is
// returned. Every output comes straight from a flop.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   in_valid / in_ready    request handshake. in_ready is high only in IDLE.
//   in_ren, in_wen         load / store select (both low = no-op)
//   in_size, in_sign       access size (0 byte .. 3 double), sign-extend loads
//   in_addr, in_wdata      byte address, right-aligned store data
//   mem_req / mem_gnt      memory request handshake
//   mem_we, mem_addr       write enable, address aligned to the bus word
//   mem_wstrb, mem_wdata   byte strobes and lane-aligned store data
//   mem_rvalid, mem_rdata  read response. It is only looked at in WAIT.
//   out_valid / out_ready  response handshake
//   out_rdata, out_err     load result (0 for stores), error flag
module ysyx_24080014_lsu #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_ren,
    input  logic                in_wen,
    input  logic [1:0]          in_size,
    input  logic                in_sign,
    input  logic [ADDR_W-1:0]   in_addr,
    input  logic [XLEN-1:0]     in_wdata,
    output logic                mem_req,
    input  logic                mem_gnt,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [XLEN/8-1:0]   mem_wstrb,
    output logic [XLEN-1:0]     mem_wdata,
    input  logic                mem_rvalid,
    input  logic [XLEN-1:0]     mem_rdata,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_rdata,
    output logic                out_err
);

    localparam int STRB_W = XLEN / 8;
    localparam int OFF_W  = $clog2(STRB_W);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_e;

    // Selects the 2^size byte field at bit 0 of raw, then sign- or zero-fills
    // the upper bits. Full-width accesses come back unchanged.
    function automatic logic [XLEN-1:0] extend_load(input logic [XLEN-1:0] raw,
                                                    input logic [1:0]      size,
                                                    input logic            sign);
        logic [XLEN-1:0] fmask;
        logic            topbit;
        case (size)
            2'd0: begin fmask = ~({XLEN{1'b1}} << 32'd8);  topbit = raw[7];  end
            2'd1: begin fmask = ~({XLEN{1'b1}} << 32'd16); topbit = raw[15]; end
            2'd2: begin fmask = ~({XLEN{1'b1}} << 32'd32); topbit = raw[31]; end
            default: begin fmask = {XLEN{1'b1}}; topbit = raw[XLEN-1]; end
        endcase
        return (raw & fmask) | ({XLEN{sign & topbit}} & ~fmask);
    endfunction

    state_e              state_q, state_d;
    logic [1:0]          size_q, size_d;
    logic                sign_q, sign_d;
    logic [OFF_W-1:0]    off_q, off_d;
    logic                in_ready_q, in_ready_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [STRB_W-1:0]   mem_wstrb_q, mem_wstrb_d;
    logic [XLEN-1:0]     mem_wdata_q, mem_wdata_d;
    logic                out_valid_q, out_valid_d;
    logic [XLEN-1:0]     out_rdata_q, out_rdata_d;
    logic                out_err_q, out_err_d;

    logic                misalign;
    logic                acc_err;
    logic [7:0]          strb_base8;
    logic [STRB_W-1:0]   strb_shifted;
    logic [OFF_W-1:0]    in_off;

    assign in_off = in_addr[OFF_W-1:0];

    // Decode alignment and strobe pattern of the incoming request.
    always_comb begin
        case (in_size)
            2'd0:    begin misalign = 1'b0;            strb_base8 = 8'h01; end
            2'd1:    begin misalign = in_addr[0];      strb_base8 = 8'h03; end
            2'd2:    begin misalign = |in_addr[1:0];   strb_base8 = 8'h0F; end
            default: begin misalign = |in_addr[2:0];   strb_base8 = 8'hFF; end
        endcase
        // A double access on a 32-bit bus has no legal lane mapping.
        acc_err      = (in_ren & in_wen) | misalign |
                       ((in_size == 2'd3) && (XLEN == 32));
        strb_shifted = STRB_W'(strb_base8) << in_off;
    end

    // Next-state and next-output computation for the request FSM.
    always_comb begin
        state_d     = state_q;
        size_d      = size_q;
        sign_d      = sign_q;
        off_d       = off_q;
        in_ready_d  = in_ready_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wstrb_d = mem_wstrb_q;
        mem_wdata_d = mem_wdata_q;
        out_valid_d = out_valid_q;
        out_rdata_d = out_rdata_q;
        out_err_d   = out_err_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    size_d     = in_size;
                    sign_d     = in_sign;
                    off_d      = in_off;
                    in_ready_d = 1'b0;
                    if (acc_err) begin
                        state_d     = S_RESP;
                        out_valid_d = 1'b1;
                        out_err_d   = 1'b1;
                        out_rdata_d = {XLEN{1'b0}};
                    end else if (!in_ren && !in_wen) begin
                        state_d     = S_RESP;
                        out_valid_d = 1'b1;
                        out_err_d   = 1'b0;
                        out_rdata_d = {XLEN{1'b0}};
                    end else begin
                        state_d     = S_REQ;
                        mem_req_d   = 1'b1;
                        mem_we_d    = in_wen;
                        mem_addr_d  = {in_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        mem_wstrb_d = in_wen ? strb_shifted : {STRB_W{1'b0}};
                        mem_wdata_d = in_wdata << {in_off, 3'b000};
                    end
                end else begin
                    in_ready_d = 1'b1;
                end
            end
            S_REQ: begin
                if (mem_gnt) begin
                    mem_req_d = 1'b0;
                    if (mem_we_q) begin
                        state_d     = S_RESP;
                        out_valid_d = 1'b1;
                        out_err_d   = 1'b0;
                        out_rdata_d = {XLEN{1'b0}};
                    end else begin
                        state_d = S_WAIT;
                    end
                end else begin
                    state_d = S_REQ;
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    state_d     = S_RESP;
                    out_valid_d = 1'b1;
                    out_err_d   = 1'b0;
                    out_rdata_d = extend_load(mem_rdata >> {off_q, 3'b000}, size_q, sign_q);
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_RESP: begin
                if (out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: begin
                state_d     = S_IDLE;
                in_ready_d  = 1'b1;
                mem_req_d   = 1'b0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers. Reset drops any in-flight access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            size_q      <= 2'd0;
            sign_q      <= 1'b0;
            off_q       <= {OFF_W{1'b0}};
            in_ready_q  <= 1'b1;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_wstrb_q <= {STRB_W{1'b0}};
            mem_wdata_q <= {XLEN{1'b0}};
            out_valid_q <= 1'b0;
            out_rdata_q <= {XLEN{1'b0}};
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            size_q      <= size_d;
            sign_q      <= sign_d;
            off_q       <= off_d;
            in_ready_q  <= in_ready_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wstrb_q <= mem_wstrb_d;
            mem_wdata_q <= mem_wdata_d;
            out_valid_q <= out_valid_d;
            out_rdata_q <= out_rdata_d;
            out_err_q   <= out_err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wstrb = mem_wstrb_q;
    assign mem_wdata = mem_wdata_q;
    assign out_valid = out_valid_q;
    assign out_rdata = out_rdata_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_ysyx_24080014_lsu.sv
// Directed bench for ysyx_24080014_lsu. It has a 32-bit instance and a 64-bit
// instance. Inputs are driven and outputs are sampled on the falling edge.
module tb_ysyx_24080014_lsu;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 32-bit instance signals
    logic        in_valid, in_ready, in_ren, in_wen, in_sign;
    logic [1:0]  in_size;
    logic [31:0] in_addr, in_wdata;
    logic        mem_req, mem_gnt, mem_we, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        out_valid, out_ready, out_err;
    logic [31:0] out_rdata;

    // 64-bit instance signals
    logic        w_in_valid, w_in_ready, w_in_ren, w_in_wen, w_in_sign;
    logic [1:0]  w_in_size;
    logic [31:0] w_in_addr;
    logic [63:0] w_in_wdata;
    logic        w_mem_req, w_mem_gnt, w_mem_we, w_mem_rvalid;
    logic [31:0] w_mem_addr;
    logic [63:0] w_mem_wdata, w_mem_rdata;
    logic [7:0]  w_mem_wstrb;
    logic        w_out_valid, w_out_ready, w_out_err;
    logic [63:0] w_out_rdata;

    int checks = 0;
    int errors = 0;

    ysyx_24080014_lsu #(.XLEN(32), .ADDR_W(32)) dut32 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_ren(in_ren), .in_wen(in_wen),
        .in_size(in_size), .in_sign(in_sign), .in_addr(in_addr), .in_wdata(in_wdata),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .out_valid(out_valid), .out_ready(out_ready),
        .out_rdata(out_rdata), .out_err(out_err)
    );

    ysyx_24080014_lsu #(.XLEN(64), .ADDR_W(32)) dut64 (
        .clk(clk), .rst(rst),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .in_ren(w_in_ren), .in_wen(w_in_wen),
        .in_size(w_in_size), .in_sign(w_in_sign), .in_addr(w_in_addr), .in_wdata(w_in_wdata),
        .mem_req(w_mem_req), .mem_gnt(w_mem_gnt), .mem_we(w_mem_we), .mem_addr(w_mem_addr),
        .mem_wstrb(w_mem_wstrb), .mem_wdata(w_mem_wdata), .mem_rvalid(w_mem_rvalid),
        .mem_rdata(w_mem_rdata), .out_valid(w_out_valid), .out_ready(w_out_ready),
        .out_rdata(w_out_rdata), .out_err(w_out_err)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Present one request for one cycle on the 32-bit instance.
    task automatic issue32(input logic ren, input logic wen, input logic [1:0] size,
                           input logic sign, input logic [31:0] addr, input logic [31:0] wdata);
        check_val("in_ready_idle", {63'd0, in_ready}, 64'd1);
        in_ren = ren; in_wen = wen; in_size = size; in_sign = sign;
        in_addr = addr; in_wdata = wdata; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_ren = 1'b0; in_wen = 1'b0;
    endtask

    task automatic finish32(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_val({tag, "_vld_drop"}, {63'd0, out_valid}, 64'd0);
        check_val({tag, "_rdy_back"}, {63'd0, in_ready}, 64'd1);
    endtask

    task automatic load32(input string tag, input logic [31:0] addr, input logic [1:0] size,
                          input logic sign, input logic [31:0] rdata,
                          input logic [31:0] exp_addr, input logic [31:0] exp);
        issue32(1'b1, 1'b0, size, sign, addr, 32'd0);
        check_val({tag, "_req"},   {63'd0, mem_req}, 64'd1);
        check_val({tag, "_busy"},  {63'd0, in_ready}, 64'd0);
        check_val({tag, "_addr"},  {32'd0, mem_addr}, {32'd0, exp_addr});
        check_val({tag, "_strb"},  {60'd0, mem_wstrb}, 64'd0);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        check_val({tag, "_reqdrop"}, {63'd0, mem_req}, 64'd0);
        check_val({tag, "_early"},   {63'd0, out_valid}, 64'd0);
        mem_rvalid = 1'b1; mem_rdata = rdata;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check_val({tag, "_vld"},  {63'd0, out_valid}, 64'd1);
        check_val({tag, "_data"}, {32'd0, out_rdata}, {32'd0, exp});
        check_val({tag, "_err"},  {63'd0, out_err}, 64'd0);
        finish32(tag);
    endtask

    task automatic store32(input string tag, input logic [31:0] addr, input logic [1:0] size,
                           input logic [31:0] wdata, input logic [31:0] exp_addr,
                           input logic [3:0] exp_strb, input logic [31:0] exp_wdata);
        issue32(1'b0, 1'b1, size, 1'b0, addr, wdata);
        check_val({tag, "_req"},   {63'd0, mem_req}, 64'd1);
        check_val({tag, "_we"},    {63'd0, mem_we}, 64'd1);
        check_val({tag, "_addr"},  {32'd0, mem_addr}, {32'd0, exp_addr});
        check_val({tag, "_strb"},  {60'd0, mem_wstrb}, {60'd0, exp_strb});
        check_val({tag, "_wdata"}, {32'd0, mem_wdata}, {32'd0, exp_wdata});
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        check_val({tag, "_vld_t2"}, {63'd0, out_valid}, 64'd1);
        check_val({tag, "_err"},    {63'd0, out_err}, 64'd0);
        check_val({tag, "_rdata"},  {32'd0, out_rdata}, 64'd0);
        check_val({tag, "_reqdrop"}, {63'd0, mem_req}, 64'd0);
        finish32(tag);
    endtask

    task automatic err32(input string tag, input logic ren, input logic wen,
                         input logic [1:0] size, input logic [31:0] addr, input logic exp_err);
        issue32(ren, wen, size, 1'b1, addr, 32'hFFFF_FFFF);
        check_val({tag, "_noreq"}, {63'd0, mem_req}, 64'd0);
        check_val({tag, "_vld_t1"}, {63'd0, out_valid}, 64'd1);
        check_val({tag, "_err"},   {63'd0, out_err}, {63'd0, exp_err});
        check_val({tag, "_rdata"}, {32'd0, out_rdata}, 64'd0);
        finish32(tag);
    endtask

    task automatic load64(input string tag, input logic [31:0] addr, input logic [1:0] size,
                          input logic sign, input logic [63:0] rdata,
                          input logic [31:0] exp_addr, input logic [63:0] exp);
        check_val({tag, "_rdy"}, {63'd0, w_in_ready}, 64'd1);
        w_in_ren = 1'b1; w_in_wen = 1'b0; w_in_size = size; w_in_sign = sign;
        w_in_addr = addr; w_in_valid = 1'b1;
        @(negedge clk);
        w_in_valid = 1'b0; w_in_ren = 1'b0;
        check_val({tag, "_req"},  {63'd0, w_mem_req}, 64'd1);
        check_val({tag, "_addr"}, {32'd0, w_mem_addr}, {32'd0, exp_addr});
        w_mem_gnt = 1'b1;
        @(negedge clk);
        w_mem_gnt = 1'b0;
        w_mem_rvalid = 1'b1; w_mem_rdata = rdata;
        @(negedge clk);
        w_mem_rvalid = 1'b0;
        check_val({tag, "_vld"},  {63'd0, w_out_valid}, 64'd1);
        check_val({tag, "_data"}, w_out_rdata, exp);
        check_val({tag, "_err"},  {63'd0, w_out_err}, 64'd0);
        w_out_ready = 1'b1;
        @(negedge clk);
        w_out_ready = 1'b0;
        check_val({tag, "_done"}, {63'd0, w_out_valid}, 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_ren = 1'b0; in_wen = 1'b0; in_size = 2'd0; in_sign = 1'b0;
        in_addr = 32'd0; in_wdata = 32'd0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        mem_rdata = 32'd0; out_ready = 1'b0;
        w_in_valid = 1'b0; w_in_ren = 1'b0; w_in_wen = 1'b0; w_in_size = 2'd0; w_in_sign = 1'b0;
        w_in_addr = 32'd0; w_in_wdata = 64'd0; w_mem_gnt = 1'b0; w_mem_rvalid = 1'b0;
        w_mem_rdata = 64'd0; w_out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rst_in_ready",  {63'd0, in_ready}, 64'd1);
        check_val("rst_mem_req",   {63'd0, mem_req}, 64'd0);
        check_val("rst_mem_addr",  {32'd0, mem_addr}, 64'd0);
        check_val("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check_val("rst_out_rdata", {32'd0, out_rdata}, 64'd0);
        check_val("rst64_in_ready", {63'd0, w_in_ready}, 64'd1);
        check_val("rst64_out_valid", {63'd0, w_out_valid}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Loads: field select, sign and zero extension
        load32("lb_s_off3", 32'h8000_0003, 2'd0, 1'b1, 32'h80FF_1234, 32'h8000_0000, 32'hFFFF_FF80);
        load32("lhu_off2",  32'h8000_0002, 2'd1, 1'b0, 32'h80FF_1234, 32'h8000_0000, 32'h0000_80FF);
        load32("lh_s_off2", 32'h8000_0002, 2'd1, 1'b1, 32'h80FF_1234, 32'h8000_0000, 32'hFFFF_80FF);
        load32("lb_s_off2", 32'h8000_0006, 2'd0, 1'b1, 32'h80FF_1234, 32'h8000_0004, 32'hFFFF_FFFF);
        load32("lbu_off1",  32'h8000_0001, 2'd0, 1'b0, 32'h80FF_1234, 32'h8000_0000, 32'h0000_0012);
        load32("lhu_off0",  32'h8000_0000, 2'd1, 1'b0, 32'h80FF_1234, 32'h8000_0000, 32'h0000_1234);
        load32("lw_s",      32'h8000_0004, 2'd2, 1'b1, 32'hDEAD_BEEF, 32'h8000_0004, 32'hDEAD_BEEF);

        // Stores: strobe and lane placement
        store32("sb_off1", 32'h8000_0001, 2'd0, 32'h0000_00AB, 32'h8000_0000, 4'b0010, 32'h0000_AB00);
        store32("sb_off3", 32'h8000_0003, 2'd0, 32'hFFFF_FF5A, 32'h8000_0000, 4'b1000, 32'h5A00_0000);
        store32("sh_off2", 32'h8000_0002, 2'd1, 32'h0000_BEEF, 32'h8000_0000, 4'b1100, 32'hBEEF_0000);
        store32("sw_off0", 32'h8000_0008, 2'd2, 32'h1122_3344, 32'h8000_0008, 4'b1111, 32'h1122_3344);

        // Errors and no-op complete without touching memory
        err32("lw_misal",  1'b1, 1'b0, 2'd2, 32'h8000_0002, 1'b1);
        err32("lh_misal",  1'b1, 1'b0, 2'd1, 32'h8000_0001, 1'b1);
        err32("ren_wen",   1'b1, 1'b1, 2'd2, 32'h8000_0000, 1'b1);
        err32("ld_dbl32",  1'b1, 1'b0, 2'd3, 32'h8000_0000, 1'b1);
        err32("noop",      1'b0, 1'b0, 2'd2, 32'h8000_0000, 1'b0);

        // Delayed grant, delayed response, back-pressured result
        issue32(1'b1, 1'b0, 2'd2, 1'b0, 32'h8000_0010, 32'd0);
        for (int i = 0; i < 3; i++) begin
            check_val("stall_req",   {63'd0, mem_req}, 64'd1);
            check_val("stall_addr",  {32'd0, mem_addr}, 64'h8000_0010);
            check_val("stall_novld", {63'd0, out_valid}, 64'd0);
            @(negedge clk);
        end
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        check_val("wait_novld", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            // A stray rvalid while holding the result must not disturb it.
            mem_rvalid = (i == 0); mem_rdata = 32'h1234_5678;
            check_val("hold_vld",   {63'd0, out_valid}, 64'd1);
            check_val("hold_rdata", {32'd0, out_rdata}, 64'hCAFE_F00D);
            check_val("hold_noreq", {63'd0, mem_req}, 64'd0);
            @(negedge clk);
        end
        mem_rvalid = 1'b0;
        check_val("hold_final", {32'd0, out_rdata}, 64'hCAFE_F00D);
        finish32("stall");
        for (int i = 0; i < 2; i++) begin
            check_val("single_noreq", {63'd0, mem_req}, 64'd0);
            check_val("single_novld", {63'd0, out_valid}, 64'd0);
            @(negedge clk);
        end

        // Reset while waiting for read data
        issue32(1'b1, 1'b0, 2'd0, 1'b0, 32'h8000_0021, 32'd0);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        rst = 1'b1;
        #1;
        check_val("arst_in_ready", {63'd0, in_ready}, 64'd1);
        check_val("arst_mem_req",  {63'd0, mem_req}, 64'd0);
        check_val("arst_mem_we",   {63'd0, mem_we}, 64'd0);
        check_val("arst_mem_addr", {32'd0, mem_addr}, 64'd0);
        check_val("arst_wstrb",    {60'd0, mem_wstrb}, 64'd0);
        check_val("arst_wdata",    {32'd0, mem_wdata}, 64'd0);
        check_val("arst_out_vld",  {63'd0, out_valid}, 64'd0);
        check_val("arst_out_rdata", {32'd0, out_rdata}, 64'd0);
        check_val("arst_out_err",  {63'd0, out_err}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        mem_rvalid = 1'b0;
        check_val("late_rvalid_novld", {63'd0, out_valid}, 64'd0);
        check_val("late_rvalid_rdy",   {63'd0, in_ready}, 64'd1);
        check_val("late_rvalid_rdata", {32'd0, out_rdata}, 64'd0);

        // 64-bit data path
        load64("ld64_s",  32'h8000_0008, 2'd3, 1'b1, 64'h8123_4567_89AB_CDEF,
               32'h8000_0008, 64'h8123_4567_89AB_CDEF);
        load64("lw64_s",  32'h8000_0004, 2'd2, 1'b1, 64'h8000_0001_0000_0000,
               32'h8000_0000, 64'hFFFF_FFFF_8000_0001);
        load64("lwu64",   32'h8000_0004, 2'd2, 1'b0, 64'h8000_0001_0000_0000,
               32'h8000_0000, 64'h0000_0000_8000_0001);
        w_in_wen = 1'b1; w_in_size = 2'd2; w_in_addr = 32'h8000_0004;
        w_in_wdata = 64'h0000_0000_AABB_CCDD; w_in_valid = 1'b1;
        @(negedge clk);
        w_in_valid = 1'b0; w_in_wen = 1'b0;
        check_val("sw64_addr",  {32'd0, w_mem_addr}, 64'h8000_0000);
        check_val("sw64_strb",  {56'd0, w_mem_wstrb}, 64'h0000_0000_0000_00F0);
        check_val("sw64_wdata", w_mem_wdata, 64'hAABB_CCDD_0000_0000);
        w_mem_gnt = 1'b1;
        @(negedge clk);
        w_mem_gnt = 1'b0;
        check_val("sw64_vld", {63'd0, w_out_valid}, 64'd1);
        w_out_ready = 1'b1;
        @(negedge clk);
        w_out_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_24080014_lsu.md
YSYX_24080014_LSU -- requirements
Module: ysyx_24080014_lsu

Interface
REQ-001 Parameter XLEN, default 32, data width; legal values 32 or 64.
REQ-002 Parameter ADDR_W, default 32, address width.
REQ-003 Port clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port rst  in  1  asynchronous, active-high reset.
REQ-005 Port in_valid  in  1  request valid.
REQ-006 Port in_ready  out  1  request accepted when in_valid & in_ready.
REQ-007 Port in_ren / in_wen  in  1 each  load / store request.
REQ-008 Port in_size  in  2  access size: 0 byte, 1 half, 2 word, 3 double.
REQ-009 Port in_sign  in  1  1 = sign-extend load, 0 = zero-extend.
REQ-010 Port in_addr  in  ADDR_W  byte address.
REQ-011 Port in_wdata  in  XLEN  store data, right-aligned.
REQ-012 Port mem_req  out  1  memory request; mem_gnt  in  1  grant.
REQ-013 Port mem_we  out  1, mem_addr  out  ADDR_W, mem_wstrb  out  XLEN/8, mem_wdata  out  XLEN.
REQ-014 Port mem_rvalid  in  1, mem_rdata  in  XLEN  read response.
REQ-015 Port out_valid  out  1, out_ready  in  1, out_rdata  out  XLEN, out_err  out  1.

Function
REQ-016 FSM states IDLE, REQ, WAIT, RESP; in_ready = 1 only in IDLE.
REQ-017 IDLE, on accept: latch ren, wen, size, sign and offset = addr[log2(XLEN/8)-1:0]; go to REQ, or to RESP if error or no-op.
REQ-018 Error = (ren & wen) | (size=3 & XLEN=32) | (addr not a multiple of 2^size); error goes to RESP with out_err=1, out_rdata=0, no mem_req.
REQ-019 No-op (ren=0, wen=0) goes to RESP with out_err=0, out_rdata=0, no mem_req.
REQ-020 REQ: mem_req=1; mem_we, mem_addr, mem_wstrb, mem_wdata registered at accept and held stable until grant.
REQ-021 mem_addr = in_addr with low log2(XLEN/8) bits cleared.
REQ-022 mem_wstrb = ((1<<2^size)-1) << offset; mem_wdata = in_wdata << (8*offset); mem_wstrb = 0 for loads.
REQ-023 REQ, mem_gnt=1: store goes to RESP; load goes to WAIT; mem_req drops in the next cycle.
REQ-024 WAIT, mem_rvalid=1: out_rdata = extend((mem_rdata >> 8*offset) masked to 2^size bytes); go to RESP.
REQ-025 Extension: in_sign=1 replicates the top bit of the selected field; in_sign=0 fills with 0; size equal to XLEN/8 passes unchanged.
REQ-026 mem_rvalid outside WAIT is ignored; memory delivers rvalid no earlier than the cycle after gnt.
REQ-027 RESP: out_valid=1; out_rdata and out_err held stable until out_ready=1, then go to IDLE.
REQ-028 Back-to-back: a new request is accepted no earlier than the cycle after the RESP handshake; one request outstanding maximum.
REQ-029 Minimum latency, accept at cycle T with immediate grant: store out_valid at T+2; load out_valid at T+2+k, where k ≥ 1 is the number of cycles from gnt to rvalid.

Reset
REQ-030 rst=1 forces IDLE immediately, asynchronously, at any state.
REQ-031 During reset: in_ready=1, mem_req=0, mem_we=0, mem_addr=0, mem_wstrb=0, mem_wdata=0, out_valid=0, out_rdata=0, out_err=0.
REQ-032 A memory response in flight at reset is discarded; a late mem_rvalid after reset is ignored per REQ-026.

Verification
REQ-033 Load byte, signed, XLEN=32: addr 0x80000003, mem_rdata 0x80FF1234 -> out_rdata 0xFFFFFF80, out_err=0.
REQ-034 Load half, unsigned: addr 0x80000002, mem_rdata 0x80FF1234 -> out_rdata 0x000080FF.
REQ-035 Store byte: addr 0x80000001, wdata 0x000000AB, immediate gnt -> mem_addr 0x80000000, mem_wstrb 0b0010, mem_wdata 0x0000AB00, mem_we=1, out_valid at T+2.
REQ-036 Load word, addr 0x80000002 -> out_err=1, out_rdata=0, mem_req never asserted, out_valid at T+1.
REQ-037 Grant delayed 3 cycles, out_ready low 2 cycles -> mem_req, mem_addr, out_valid, out_rdata stable throughout; one transaction only.
REQ-038 rst pulsed in WAIT, then mem_rvalid arrives -> all outputs 0 during reset, in_ready=1, no out_valid.
REQ-039 XLEN=64: load double, signed, addr 0x...08 -> full 64-bit passthrough; load word, signed, addr 0x...04, mem_rdata 0x8000000100000000 -> out_rdata 0xFFFFFFFF80000001.
